// File: rtl/fifo_param.sv
// ---------------------------------------------------------------------------
// fifo_param
// Parametrised synchronous FIFO with programmable almost-full/almost-empty
// thresholds, an occupancy count, overflow/underflow error pulses and a
// synchronous flush.
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst           asynchronous active-high reset
//   i_flush         synchronous clear of pointers and count
//   i_wr_cs/i_wr_en write request when both high
//   i_data_in       write data
//   i_rd_cs/i_rd_en read request when both high
//   o_data_out      registered read data, holds between accepted reads
//   o_full/o_empty  count == DEPTH / count == 0
//   o_almost_full   count >= AF_THRESH
//   o_almost_empty  count <= AE_THRESH
//   o_count         occupancy 0..DEPTH
//   o_overflow      one-cycle pulse after a rejected write request
//   o_underflow     one-cycle pulse after a rejected read request
// ---------------------------------------------------------------------------
module fifo_param #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2,
   localparam int AW        = $clog2(DEPTH),
   localparam int CW        = $clog2(DEPTH) + 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_flush,
   input  logic                  i_wr_cs,
   input  logic                  i_wr_en,
   input  logic [DATA_WIDTH-1:0] i_data_in,
   input  logic                  i_rd_cs,
   input  logic                  i_rd_en,
   output logic [DATA_WIDTH-1:0] o_data_out,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_almost_full,
   output logic                  o_almost_empty,
   output logic [CW-1:0]         o_count,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  overflow;
   logic                  underflow;

   logic wr_req;
   logic rd_req;
   logic wr_acc;
   logic rd_acc;

   // Flags come straight from the count register, so they change on the
   // same edge as the count and have no path from the inputs.
   assign o_full         = (count == FULL_C);
   assign o_empty        = (count == '0);
   assign o_almost_full  = (count >= AF_C);
   assign o_almost_empty = (count <= AE_C);
   assign o_count        = count;
   assign o_data_out     = data_out;
   assign o_overflow     = overflow;
   assign o_underflow    = underflow;

   assign wr_req = i_wr_cs && i_wr_en;
   assign rd_req = i_rd_cs && i_rd_en;
   // Acceptance looks only at the start-of-cycle flags: a full FIFO refuses
   // a write even if a read frees a slot this cycle, and an empty FIFO never
   // lets a same-cycle write fall through to the read port.
   assign wr_acc = wr_req && !o_full  && !i_flush;
   assign rd_acc = rd_req && !o_empty && !i_flush;

   // Storage has no reset; a reset or flush discards contents logically
   // through the pointers and count.
   always_ff @(posedge i_clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= i_data_in;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         data_out  <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         // A flush suppresses both acceptance and the error pulses.
         overflow  <= wr_req && o_full  && !i_flush;
         underflow <= rd_req && o_empty && !i_flush;
         if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            // DEPTH is a power of two, so the pointers wrap on their own.
            if (wr_acc) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
               rd_ptr   <= rd_ptr + 1'b1;
               data_out <= mem[rd_ptr];
            end
            case ({wr_acc, rd_acc})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_param
// Self-checking bench for fifo_param with default parameters (8 x 16).
// A vector table covers fill/drain, chip-select gating and the empty
// read+write case; hand-written sequences cover wrap-around, simultaneous
// access at count 5 and 16, flush, and asynchronous reset mid-operation.
// ---------------------------------------------------------------------------
module tb_fifo_param;

   logic       clk;
   logic       rst;
   logic       flush;
   logic       wr_cs;
   logic       wr_en;
   logic [7:0] data_in;
   logic       rd_cs;
   logic       rd_en;
   logic [7:0] data_out;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int n_checks = 0;
   int n_errors = 0;

   fifo_param #(.DATA_WIDTH(8), .DEPTH(16)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_flush        (flush),
      .i_wr_cs        (wr_cs),
      .i_wr_en        (wr_en),
      .i_data_in      (data_in),
      .i_rd_cs        (rd_cs),
      .i_rd_en        (rd_en),
      .o_data_out     (data_out),
      .o_full         (full),
      .o_empty        (empty),
      .o_almost_full  (almost_full),
      .o_almost_empty (almost_empty),
      .o_count        (count),
      .o_overflow     (overflow),
      .o_underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic       flush;
      logic       wcs;
      logic       wen;
      logic [7:0] din;
      logic       rcs;
      logic       ren;
      logic [7:0] dout;
      logic [4:0] cnt;
      logic       ovf;
      logic       unf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic fl, logic wcs, logic wen, logic [7:0] din,
                               logic rcs, logic ren, logic [7:0] dout,
                               logic [4:0] cnt, logic ovf, logic unf);
      vec_t v;
      v.flush = fl;  v.wcs = wcs; v.wen = wen; v.din = din;
      v.rcs   = rcs; v.ren = ren; v.dout = dout; v.cnt = cnt;
      v.ovf   = ovf; v.unf = unf;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Flags are implied by the expected count with default thresholds
   // (full at 16, almost-full from 14, almost-empty up to 2).
   task automatic chk_state(string tag, int cnt, int dout, bit ovf, bit unf);
      chk({tag, ".count"},    32'(count),        32'(cnt));
      chk({tag, ".dout"},     32'(data_out),     32'(dout));
      chk({tag, ".full"},     32'(full),         32'(cnt == 16));
      chk({tag, ".empty"},    32'(empty),        32'(cnt == 0));
      chk({tag, ".afull"},    32'(almost_full),  32'(cnt >= 14));
      chk({tag, ".aempty"},   32'(almost_empty), 32'(cnt <= 2));
      chk({tag, ".overflow"}, 32'(overflow),     32'(ovf));
      chk({tag, ".underflow"},32'(underflow),    32'(unf));
   endtask

   task automatic cyc(logic fl, logic w, logic [7:0] d, logic r);
      flush = fl; wr_cs = w; wr_en = w; data_in = d; rd_cs = r; rd_en = r;
      @(posedge clk);
      #1;
      flush = 1'b0; wr_cs = 1'b0; wr_en = 1'b0; rd_cs = 1'b0; rd_en = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_q[$];
      logic [7:0] e;

      rst = 1'b1; flush = 1'b0; wr_cs = 1'b0; wr_en = 1'b0; data_in = 8'h00;
      rd_cs = 1'b0; rd_en = 1'b0;

      // Fill 0x00..0x0F, 17th write of 0xAA overflows.
      for (int i = 0; i < 16; i++)
         vecs.push_back(mk(0, 1, 1, 8'(i), 0, 0, 8'h00, 5'(i + 1), 0, 0));
      vecs.push_back(mk(0, 1, 1, 8'hAA, 0, 0, 8'h00, 5'd16, 1, 0));
      // Drain in order, 17th read underflows and output holds 0x0F.
      for (int i = 0; i < 16; i++)
         vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 8'(i), 5'(15 - i), 0, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 8'h0F, 5'd0, 0, 1));
      // Chip-select gating: enables without selects and selects without enables.
      vecs.push_back(mk(0, 0, 1, 8'h77, 0, 1, 8'h0F, 5'd0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 8'h78, 1, 0, 8'h0F, 5'd0, 0, 0));
      // Empty: read+write together, write accepted, read rejected.
      vecs.push_back(mk(0, 1, 1, 8'h55, 1, 1, 8'h0F, 5'd1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h0F, 5'd1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 8'h55, 5'd0, 0, 0));

      #2;
      chk_state("reset", 0, 0, 0, 0);
      #10;
      rst = 1'b0;   // released between edges; next edge takes the first vector

      foreach (vecs[k]) begin
         flush = vecs[k].flush; wr_cs = vecs[k].wcs; wr_en = vecs[k].wen;
         data_in = vecs[k].din; rd_cs = vecs[k].rcs; rd_en = vecs[k].ren;
         @(posedge clk);
         #1;
         chk_state($sformatf("vec%0d", k), int'(vecs[k].cnt), int'(vecs[k].dout),
                   vecs[k].ovf, vecs[k].unf);
      end
      flush = 1'b0; wr_cs = 1'b0; wr_en = 1'b0; rd_cs = 1'b0; rd_en = 1'b0;

      // Wrap-around: pointers start at 1 here, so the 12-word pass wraps.
      for (int i = 0; i < 10; i++) begin
         cyc(0, 1, 8'(8'h10 + i), 0);
         exp_q.push_back(8'(8'h10 + i));
      end
      chk("wrap.count10", 32'(count), 32'd10);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 8'h00, 1);
         e = exp_q.pop_front();
         chk("wrap.rd_a", 32'(data_out), 32'(e));
      end
      for (int i = 0; i < 12; i++) begin
         cyc(0, 1, 8'(8'h30 + i), 0);
         exp_q.push_back(8'(8'h30 + i));
      end
      chk("wrap.count12", 32'(count), 32'd12);
      for (int i = 0; i < 12; i++) begin
         cyc(0, 0, 8'h00, 1);
         e = exp_q.pop_front();
         chk("wrap.rd_b", 32'(data_out), 32'(e));
      end
      chk_state("wrap.end", 0, 8'h3B, 0, 0);

      // Count 5: simultaneous read and write keeps count and order.
      for (int i = 0; i < 5; i++) cyc(0, 1, 8'(8'h60 + i), 0);
      cyc(0, 1, 8'h65, 1);
      chk_state("sim5", 5, 8'h60, 0, 0);
      for (int i = 1; i < 6; i++) begin
         cyc(0, 0, 8'h00, 1);
         chk("sim5.rd", 32'(data_out), 32'(8'h60 + i));
      end
      chk_state("sim5.end", 0, 8'h65, 0, 0);

      // Count 16: read accepted, write rejected with overflow pulse.
      for (int i = 0; i < 16; i++) cyc(0, 1, 8'(8'h80 + i), 0);
      chk_state("sim16.full", 16, 8'h65, 0, 0);
      cyc(0, 1, 8'hEE, 1);
      chk_state("sim16", 15, 8'h80, 1, 0);
      for (int i = 1; i < 16; i++) begin
         cyc(0, 0, 8'h00, 1);
         chk("sim16.rd", 32'(data_out), 32'(8'h80 + i));
      end
      chk_state("sim16.end", 0, 8'h8F, 0, 0);

      // Flush with a concurrent write and read.
      for (int i = 0; i < 7; i++) cyc(0, 1, 8'(8'hA0 + i), 0);
      chk_state("flush.pre", 7, 8'h8F, 0, 0);
      cyc(1, 1, 8'hBB, 1);
      chk_state("flush", 0, 8'h8F, 0, 0);
      cyc(0, 1, 8'hC1, 0);
      chk_state("flush.wr", 1, 8'h8F, 0, 0);
      cyc(0, 0, 8'h00, 1);
      chk_state("flush.rd", 0, 8'hC1, 0, 0);

      // Asynchronous reset at count 9, asserted between edges.
      for (int i = 0; i < 9; i++) cyc(0, 1, 8'(8'hD0 + i), 0);
      chk_state("rst.pre", 9, 8'hC1, 0, 0);
      #3;
      rst = 1'b1;
      #1;
      chk_state("rst.async", 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk_state("rst.hold", 0, 0, 0, 0);
      #2;
      rst = 1'b0;
      for (int i = 0; i < 16; i++) cyc(0, 1, 8'(8'hE0 + i), 0);
      chk_state("rst.refill", 16, 0, 0, 0);
      cyc(0, 1, 8'h11, 0);
      chk_state("rst.ovf", 16, 0, 1, 0);
      cyc(0, 0, 8'h00, 1);
      chk_state("rst.rd", 15, 8'hE0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO. It is the DUT behind the FIFO driver and monitor interfaces and replaces the fixed 8-bit FIFO. Width and depth are configurable. New over the previous generation:
- programmable almost-full and almost-empty thresholds;
- an occupancy count output;
- overflow and underflow error pulses;
- a synchronous flush.

## Interface
- DATA_WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_THRESH, DEPTH-2, o_almost_full asserted when count ≥ AF_THRESH
- AE_THRESH, 2, o_almost_empty asserted when count ≤ AE_THRESH
- CW (localparam), $clog2(DEPTH)+1, count width

Ports:
- i_clk  in  1  clock; all logic on the rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_flush  in  1  synchronous clear of contents
- i_wr_cs  in  1  write-side chip select
- i_wr_en  in  1  write enable
- i_data_in  in  DATA_WIDTH  write data
- i_rd_cs  in  1  read-side chip select
- i_rd_en  in  1  read enable
- o_data_out  out  DATA_WIDTH  registered read data
- o_full  out  1  count == DEPTH
- o_empty  out  1  count == 0
- o_almost_full  out  1  count ≥ AF_THRESH
- o_almost_empty  out  1  count ≤ AE_THRESH
- o_count  out  CW  current occupancy, 0..DEPTH
- o_overflow  out  1  one-cycle pulse: write request rejected
- o_underflow  out  1  one-cycle pulse: read request rejected

## Operation
- Write request: i_wr_cs && i_wr_en. Read request: i_rd_cs && i_rd_en.
- Write accepted only if request && !o_full && !i_flush. The word is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
- Read accepted only if request && !o_empty && !i_flush. o_data_out loads mem[rd_ptr], and rd_ptr increments modulo DEPTH.
- Acceptance is evaluated against the flags at the start of the cycle. A full FIFO rejects a write even when a read is accepted in the same cycle. An empty FIFO rejects a read even when a write is accepted in the same cycle (no fall-through).
- Count update: +1 for an accepted write only; −1 for an accepted read only; unchanged for both or neither.
- Storage: DEPTH × DATA_WIDTH register array with binary pointers of width $clog2(DEPTH). Full and empty are decoded from the count, not from pointer comparison.
- Flags are decoded from the registered count. They therefore change on the same edge as the count.
- Rejected write request → o_overflow = 1 for the next cycle. Rejected read request → o_underflow = 1 for the next cycle. Both may pulse together.
- Flush: pointers and count go to 0, and no access is accepted that cycle. No error pulses are generated and mem contents are not cleared. o_data_out holds its value.
- o_data_out holds its value in every cycle without an accepted read.
- Reset at any time, including mid-burst, forces every output to its reset value immediately. Stored data is discarded logically (the count returns to 0).
- Reset values:
  - o_data_out 0, o_count 0
  - o_empty 1, o_full 0
  - o_almost_empty 1, o_almost_full 0 (with default thresholds)
  - o_overflow 0, o_underflow 0
  - wr_ptr 0, rd_ptr 0

## Timing
- Write latency: data written at edge N is readable by a request sampled at edge N+1. o_data_out shows it after edge N+1.
- Read latency: 1 cycle. Data appears on o_data_out after the edge that accepts the read.
- Flags, o_count and error pulses are all registered and valid one cycle after the causing edge. No combinational input-to-output paths.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. Sustained simultaneous read and write at any occupancy between 1 and DEPTH-1 gives 1 word/cycle throughput.
- Asynchronous reset release: the first access is accepted on the first rising edge with i_rst low.

## Test plan
(DATA_WIDTH = 8, DEPTH = 16, defaults.)
- Fill/drain: write 0x00..0x0F on 16 consecutive cycles, then a 17th write of 0xAA.
  - o_full rises after the 16th write, with o_count = 16 and o_almost_full from count 14.
  - The 17th write gives a single o_overflow pulse.
  - 16 reads then return 0x00..0x0F in order. A 17th read gives an o_underflow pulse and o_data_out stays 0x0F.
- Wrap-around: write 10 words, read 10, write 12, read 12. Data stays in order across the pointer wrap and o_count ends at 0.
- Simultaneous access:
  - At count 5, read and write together: count stays 5 and data order is preserved.
  - At count 16, read and write together: read accepted, write rejected, o_overflow pulses, count goes to 15.
  - At count 0, read and write together: write accepted, o_underflow pulses, count goes to 1.
- Chip select gating: wr_en = 1 with wr_cs = 0, and rd_en = 1 with rd_cs = 0. No count change and no error pulses.
- Flush: load 7 words, then assert i_flush together with a write and a read.
  - Count goes to 0, o_empty = 1, no error pulses, o_data_out unchanged.
  - The next write/read pair returns the new word.
- Reset mid-operation: assert i_rst asynchronously between edges at count 9. All outputs take their reset values immediately (o_empty = 1, o_data_out = 0x00). After release, normal fill works.
